// File: rtl/btn_sw_debouncer.sv
// Two-stage synchroniser plus independent per-bit debounce filter for board switches and buttons.
// Define BTN_TOGGLE_EN to add the grp_off latched toggle mask driven by button presses.
module btn_sw_debouncer #(
    parameter int N_BTN      = 4,
    parameter int N_SW       = 16,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_press
`ifdef BTN_TOGGLE_EN
    ,
    output logic [N_BTN-1:0] grp_off
`endif
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int N     = N_SW + N_BTN;

    logic [N-1:0] raw;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] stable;
    logic [N-1:0] upd;

    assign raw = {btn_raw, sw_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_filt
        logic [CNT_W-1:0] cnt_q;
        logic             stab_q;

        // upd fires on the DEB_CYCLES-th consecutive sample that differs from the output
        assign upd[i]    = (s2[i] != stab_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
        assign stable[i] = stab_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                stab_q <= 1'b0;
            end else if (s2[i] == stab_q) begin
                cnt_q <= '0;
            end else if (upd[i]) begin
                cnt_q  <= '0;
                stab_q <= s2[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sw_db  = stable[N_SW-1:0];
    assign btn_db = stable[N-1:N_SW];

    // Press pulse registers on the same edge the debounced level first goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_press <= '0;
        end else begin
            btn_press <= upd[N-1:N_SW] & s2[N-1:N_SW];
        end
    end

`ifdef BTN_TOGGLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_off <= '0;
        end else begin
            grp_off <= grp_off ^ btn_press;
        end
    end
`endif

endmodule

// File: tb/tb_btn_sw_debouncer.sv
// Directed bench for btn_sw_debouncer with DEB_CYCLES=8 (input step to output = 10 edges).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_btn_sw_debouncer;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [15:0] sw_db;
    logic [3:0]  btn_db;
    logic [3:0]  btn_press;
`ifdef BTN_TOGGLE_EN
    logic [3:0]  grp_off;
`endif

    int tests = 0;
    int fails = 0;

    btn_sw_debouncer #(
        .N_BTN(4),
        .N_SW(16),
        .DEB_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .sw_db(sw_db),
        .btn_db(btn_db),
        .btn_press(btn_press)
`ifdef BTN_TOGGLE_EN
        ,
        .grp_off(grp_off)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int presses;

        // 1. Reset with everything held high
        rst_n   = 1'b0;
        sw_raw  = 16'hFFFF;
        btn_raw = 4'hF;
        tick(3);
        chk("rst_sw_db", 32'(sw_db), 32'h0);
        chk("rst_btn_db", 32'(btn_db), 32'h0);
        chk("rst_press", 32'(btn_press), 32'h0);
`ifdef BTN_TOGGLE_EN
        chk("rst_grp_off", 32'(grp_off), 32'h0);
`endif
        rst_n = 1'b1;
        tick(9);
        chk("rst_rel_sw_early", 32'(sw_db), 32'h0);
        chk("rst_rel_press_early", 32'(btn_press), 32'h0);
        tick(1);
        chk("rst_rel_sw_db", 32'(sw_db), 32'hFFFF);
        chk("rst_rel_btn_db", 32'(btn_db), 32'hF);
        chk("rst_rel_press", 32'(btn_press), 32'hF);
        tick(1);
        chk("rst_rel_press_end", 32'(btn_press), 32'h0);

        // 2. Clean press of btn0
        sw_raw  = 16'h0000;
        btn_raw = 4'h0;
        tick(12);
        chk("release_all_btn", 32'(btn_db), 32'h0);
        chk("release_all_sw", 32'(sw_db), 32'h0);
        chk("release_no_press", 32'(btn_press), 32'h0);
        btn_raw = 4'h1;
        tick(9);
        chk("press_early", 32'(btn_db), 32'h0);
        tick(1);
        chk("press_db", 32'(btn_db), 32'h1);
        chk("press_pulse", 32'(btn_press), 32'h1);
        tick(1);
        chk("press_pulse_end", 32'(btn_press), 32'h0);
        chk("press_db_held", 32'(btn_db), 32'h1);

        // 3. Bounce on btn2: 3-cycle runs never reach 8
        presses = 0;
        for (int p = 0; p < 10; p++) begin
            btn_raw[2] = (p % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (btn_press != 4'h0) presses++;
                if (btn_db != 4'h1) presses += 100;
            end
        end
        chk("bounce_quiet", 32'(presses), 32'h0);
        btn_raw[2] = 1'b1;
        tick(9);
        chk("bounce_early", 32'(btn_db), 32'h1);
        tick(1);
        chk("bounce_db", 32'(btn_db), 32'h5);
        chk("bounce_press", 32'(btn_press), 32'h4);
        presses = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (btn_press != 4'h0) presses++;
        end
        chk("bounce_single_pulse", 32'(presses), 32'h0);

        // 4. Glitch rejection on sw7
        sw_raw[7] = 1'b1;
        tick(7);
        sw_raw[7] = 1'b0;
        presses = 0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (sw_db != 16'h0) presses++;
        end
        chk("glitch7_reject", 32'(presses), 32'h0);
        sw_raw[7] = 1'b1;
        tick(8);
        sw_raw[7] = 1'b0;
        tick(1);
        chk("glitch8_early", 32'(sw_db), 32'h0);
        tick(1);
        chk("glitch8_rise", 32'(sw_db), 32'h0080);
        tick(7);
        chk("glitch8_hold", 32'(sw_db), 32'h0080);
        tick(1);
        chk("glitch8_fall", 32'(sw_db), 32'h0);

        // 5. Simultaneous pattern
        btn_raw = 4'h0;
        tick(12);
        chk("pat_clear", 32'(btn_db), 32'h0);
        sw_raw  = 16'hA5A5;
        btn_raw = 4'b0101;
        tick(9);
        chk("pat_early_sw", 32'(sw_db), 32'h0);
        tick(1);
        chk("pat_sw_db", 32'(sw_db), 32'hA5A5);
        chk("pat_btn_db", 32'(btn_db), 32'h5);
        chk("pat_press", 32'(btn_press), 32'h5);
        tick(1);
        chk("pat_press_end", 32'(btn_press), 32'h0);

        // 6. Fresh reset, then reset in the middle of a count
        sw_raw  = 16'h0;
        btn_raw = 4'h0;
        rst_n   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        btn_raw = 4'h1;
        tick(7);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_db", 32'(btn_db), 32'h0);
        chk("midrst_press", 32'(btn_press), 32'h0);
        rst_n = 1'b1;
        tick(9);
        chk("midrst_early", 32'(btn_db), 32'h0);
        chk("midrst_no_press", 32'(btn_press), 32'h0);
        tick(1);
        chk("midrst_db_rise", 32'(btn_db), 32'h1);
        chk("midrst_press_rise", 32'(btn_press), 32'h1);
`ifdef BTN_TOGGLE_EN
        chk("tog1_before", 32'(grp_off), 32'h0);
        tick(1);
        chk("tog1_after", 32'(grp_off), 32'h1);
        btn_raw = 4'h0;
        tick(12);
        chk("tog_release_keep", 32'(grp_off), 32'h1);
        btn_raw = 4'h1;
        tick(10);
        chk("tog2_press", 32'(btn_press), 32'h1);
        chk("tog2_before", 32'(grp_off), 32'h1);
        tick(1);
        chk("tog2_after", 32'(grp_off), 32'h0);
`else
        tick(1);
        chk("midrst_press_end", 32'(btn_press), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
